fabric_sequencer: RTL and testbench

FABRIC_SEQUENCER -- requirements
Module: fabric_sequencer

---
 rtl/fabric_seq_pkg.sv | 18 +
 rtl/fabric_seq_fifo.sv | 52 +++++
 rtl/fabric_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fabric_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_seq_pkg.sv
// Shared types and helpers for the fabric instruction sequencer.
package fabric_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALL = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } fabric_seq_state_t;

  // Row-select width; a single-row fabric still carries a 1-bit row field.
  function automatic int unsigned rw_width(input int unsigned rows);
    if (rows > 1) return $unsigned($clog2(rows));
    return 1;
  endfunction

endpackage

// File: rtl/fabric_seq_fifo.sv
// Synchronous single-clock FIFO with full/empty flags and occupancy count.
module fabric_seq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fabric_sequencer.sv
// Buffers instructions, streams them to fabric rows, then calls rows and waits for returns.
// Optional WAIT timeout enabled by defining FABRIC_SEQ_TIMEOUT_EN.
module fabric_sequencer
  import fabric_seq_pkg::*;
#(
  parameter int unsigned ROWS             = 1,
  parameter int unsigned INSTR_DATA_WIDTH = 27,
  parameter int unsigned INSTR_ADDR_WIDTH = 4,
  parameter int unsigned INSTR_HOPS_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [rw_width(ROWS)-1:0]                s_row,
  input  logic [INSTR_DATA_WIDTH-1:0]              s_data,
  input  logic [INSTR_ADDR_WIDTH-1:0]              s_addr,
  input  logic [INSTR_HOPS_WIDTH-1:0]              s_hops,
  input  logic                                     start,
  input  logic [ROWS-1:0]                          start_mask,
  output logic [ROWS-1:0]                          instr_en_out,
  output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]    instr_data_out,
  output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]    instr_addr_out,
  output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]    instr_hops_out,
  output logic [ROWS-1:0]                          call,
  input  logic [ROWS-1:0]                          ret,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     timeout_err
);

  localparam int unsigned RW = rw_width(ROWS);
  localparam int unsigned EW = RW + INSTR_DATA_WIDTH + INSTR_ADDR_WIDTH + INSTR_HOPS_WIDTH;

  if (ROWS == 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("fabric_sequencer: illegal parameter set");
  end

  fabric_seq_state_t             state;
  logic [ROWS-1:0]               mask;
  logic [ROWS-1:0]               pending;
  logic [ROWS-1:0]               pending_clr;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [EW-1:0]                 fifo_rdata;
  logic [RW-1:0]                 pop_row;
  logic [INSTR_DATA_WIDTH-1:0]   pop_data;
  logic [INSTR_ADDR_WIDTH-1:0]   pop_addr;
  logic [INSTR_HOPS_WIDTH-1:0]   pop_hops;
  logic                          pop_row_ok;

  fabric_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata ({s_row, s_data, s_addr, s_hops}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_ready     = !fifo_full && !rst;
  assign fifo_pop    = (state == ST_LOAD) && !fifo_empty;
  assign {pop_row, pop_data, pop_addr, pop_hops} = fifo_rdata;
  assign pop_row_ok  = (32'(pop_row) < ROWS);
  assign pending_clr = pending & ~ret;
  assign busy        = (state != ST_IDLE);

`ifdef FABRIC_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      mask           <= '0;
      pending        <= '0;
      instr_en_out   <= '0;
      instr_data_out <= '0;
      instr_addr_out <= '0;
      instr_hops_out <= '0;
      call           <= '0;
      done           <= 1'b0;
`ifdef FABRIC_SEQ_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      instr_en_out   <= '0;
      instr_data_out <= '0;
      instr_addr_out <= '0;
      instr_hops_out <= '0;
      call           <= '0;
      done           <= 1'b0;

      // Out-of-range rows are popped and silently dropped.
      if (fifo_pop && pop_row_ok) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          if (pop_row == RW'(r)) begin
            instr_en_out[r]   <= 1'b1;
            instr_data_out[r] <= pop_data;
            instr_addr_out[r] <= pop_addr;
            instr_hops_out[r] <= pop_hops;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            mask  <= start_mask;
`ifdef FABRIC_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (fifo_count == '0) begin
            state   <= ST_CALL;
            call    <= mask;
            pending <= mask;
          end
        end
        ST_CALL: begin
          state   <= ST_WAIT;
          pending <= pending_clr;
`ifdef FABRIC_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          pending <= pending_clr;
          if (pending_clr == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
`ifdef FABRIC_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_sequencer.sv
// Scoreboard bench for fabric_sequencer (ROWS=2); timeout scenario runs when FABRIC_SEQ_TIMEOUT_EN is defined.
module tb_fabric_sequencer;

  localparam int unsigned ROWS = 2;
  localparam int unsigned DW   = 27;
  localparam int unsigned AW   = 4;
  localparam int unsigned HW   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO   = 16;

  typedef struct packed {
    logic [0:0]    row;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [HW-1:0] hops;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic s_valid;
  logic s_ready;
  logic [0:0] s_row;
  logic [DW-1:0] s_data;
  logic [AW-1:0] s_addr;
  logic [HW-1:0] s_hops;
  logic start;
  logic [ROWS-1:0] start_mask;
  logic [ROWS-1:0] instr_en_out;
  logic [ROWS-1:0][DW-1:0] instr_data_out;
  logic [ROWS-1:0][AW-1:0] instr_addr_out;
  logic [ROWS-1:0][HW-1:0] instr_hops_out;
  logic [ROWS-1:0] call;
  logic [ROWS-1:0] ret;
  logic busy;
  logic done;
  logic timeout_err;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  fabric_sequencer #(
    .ROWS             (ROWS),
    .INSTR_DATA_WIDTH (DW),
    .INSTR_ADDR_WIDTH (AW),
    .INSTR_HOPS_WIDTH (HW),
    .FIFO_DEPTH       (DEPTH),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_row          (s_row),
    .s_data         (s_data),
    .s_addr         (s_addr),
    .s_hops         (s_hops),
    .start          (start),
    .start_mask     (start_mask),
    .instr_en_out   (instr_en_out),
    .instr_data_out (instr_data_out),
    .instr_addr_out (instr_addr_out),
    .instr_hops_out (instr_hops_out),
    .call           (call),
    .ret            (ret),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one push for a cycle; accepted entries go to the scoreboard when tracked.
  task automatic push(input logic [0:0] row, input bit track);
    exp_t e;
    e.row  = row;
    e.data = DW'($urandom);
    e.addr = AW'($urandom);
    e.hops = HW'($urandom);
    s_valid = 1'b1;
    s_row   = e.row;
    s_data  = e.data;
    s_addr  = e.addr;
    s_hops  = e.hops;
    if (s_ready && track) sb_q.push_back(e);
    step();
    s_valid = 1'b0;
  endtask

  task automatic start_run(input logic [ROWS-1:0] m);
    start      = 1'b1;
    start_mask = m;
    step();
    start = 1'b0;
  endtask

  // Echo each call back as ret and wait (bounded) for done, then return to IDLE.
  task automatic run_to_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      ret = call;
      step();
      if (done) seen = 1'b1;
    end
    ret = '0;
    check(tag, 64'(seen), 64'(1));
    step();
  endtask

  // Every fabric enable pulse must match the oldest outstanding pushed entry.
  always @(negedge clk) begin
    if (!rst && instr_en_out != '0) begin
      if (sb_q.size() == 0) begin
        check("en_unexpected", 64'(instr_en_out), 64'(0));
      end else begin
        exp_t e;
        logic [ROWS-1:0] en_exp;
        e = sb_q.pop_front();
        en_exp = 2'b01 << e.row;
        check("en_row", 64'(instr_en_out), 64'(en_exp));
        check("data", 64'(instr_data_out[e.row]), 64'(e.data));
        check("addr", 64'(instr_addr_out[e.row]), 64'(e.addr));
        check("hops", 64'(instr_hops_out[e.row]), 64'(e.hops));
        check("other_row_zero", 64'({instr_data_out[~e.row], instr_addr_out[~e.row],
                                     instr_hops_out[~e.row]}), 64'(0));
      end
    end
  end

  initial begin
    logic [ROWS-1:0] en_exp [4];
    en_exp = '{2'b01, 2'b10, 2'b01, 2'b00};
    rst = 1'b1; s_valid = 1'b0; s_row = '0; s_data = '0; s_addr = '0; s_hops = '0;
    start = 1'b0; start_mask = '0; ret = '0;
    step(); step();
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_outs", 64'({instr_en_out, call, done, timeout_err}), 64'(0));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(s_ready), 64'(1));

    // Three entries, rows 0,1,0, both rows called.
    push(1'b0, 1'b1); push(1'b1, 1'b1); push(1'b0, 1'b1);
    start_run(2'b11);
    check("busy_load", 64'(busy), 64'(1));
    for (int k = 0; k < 4; k++) begin
      step();
      check("en_seq", 64'(instr_en_out), 64'(en_exp[k]));
    end
    check("call_mask", 64'(call), 64'(2'b11));
    step();
    check("call_one_cycle", 64'(call), 64'(0));
    ret = 2'b10;
    step();
    check("done_wait1", 64'(done), 64'(0));
    ret = 2'b00;
    step();
    check("done_wait2", 64'(done), 64'(0));
    ret = 2'b01;
    step();
    check("done_pulse", 64'(done), 64'(1));
    ret = 2'b00;
    step();
    check("done_clear", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("sb_drain_a", 64'(sb_q.size()), 64'(0));

    // Empty FIFO, mask 0; start held high while busy must be ignored.
    start = 1'b1; start_mask = 2'b00;
    step();
    check("m0_busy", 64'(busy), 64'(1));
    start_mask = 2'b11;
    step();
    check("m0_call", 64'(call), 64'(0));
    step();
    check("m0_done_early", 64'(done), 64'(0));
    start = 1'b0;
    step();
    check("m0_done", 64'(done), 64'(1));
    check("m0_call_late", 64'(call), 64'(0));
    step();
    check("m0_idle", 64'({busy, done}), 64'(0));

    // Fill to depth, try one extra push, then one pop frees space.
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("fill_ready", 64'(s_ready), 64'(1));
      push(1'(i), 1'b1);
    end
    check("full_ready", 64'(s_ready), 64'(0));
    push(1'b1, 1'b0);
    check("full_hold", 64'(s_ready), 64'(0));
    start_run(2'b01);
    check("full_load", 64'(s_ready), 64'(0));
    step();
    check("ready_restore", 64'(s_ready), 64'(1));
    push(1'b1, 1'b1);
    run_to_done("full_run_done");
    check("sb_drain_b", 64'(sb_q.size()), 64'(0));

`ifdef FABRIC_SEQ_TIMEOUT_EN
    start_run(2'b01);
    for (int i = 0; i < 17; i++) step();
    check("to_done_early", 64'({done, timeout_err}), 64'(0));
    step();
    check("to_done", 64'(done), 64'(1));
    check("to_err", 64'(timeout_err), 64'(1));
    step();
    check("to_sticky", 64'({timeout_err, busy}), 64'(2'b10));
    start_run(2'b00);
    check("to_cleared", 64'(timeout_err), 64'(0));
    run_to_done("to_next_done");
`endif

    // Reset during WAIT with two entries queued behind the run.
    start_run(2'b01);
    step(); step();
    push(1'b0, 1'b0); push(1'b1, 1'b0);
`ifndef FABRIC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 20; i++) step();
    check("wait_forever", 64'({busy, done, timeout_err}), 64'(3'b100));
`endif
    rst = 1'b1;
    step();
    check("mid_rst_outs", 64'({instr_en_out, call, busy, done, timeout_err, s_ready}), 64'(0));
    rst = 1'b0;
    step();
    check("mid_rst_ready", 64'(s_ready), 64'(1));
    start_run(2'b00);
    run_to_done("post_rst_done");
    check("post_rst_sb", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
